// File: rtl/change_logger.sv
// change_logger: watches CHANNELS data lanes, records a timestamped event
// whenever any lane changes value, and queues events in a small
// first-word-fall-through FIFO with overflow tracking.
module change_logger #(
  parameter int DATA_W   = 4,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,   // power of two, >= 2
  parameter int TS_W     = 16,
  localparam int EVT_W   = TS_W + CHANNELS + CHANNELS*DATA_W,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [CHANNELS*DATA_W-1:0] ch_data,
  input  logic                       rd_en,
  input  logic                       clr,
  output logic                       evt_valid,
  output logic [TS_W-1:0]            evt_ts,
  output logic [CHANNELS-1:0]        evt_mask,
  output logic [CHANNELS*DATA_W-1:0] evt_data,
  output logic [LVL_W-1:0]           level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [TS_W-1:0]            ts_q;
  logic [CHANNELS*DATA_W-1:0] prev_q;
  logic                       primed_q;
  logic [CHANNELS-1:0]        mask;
  logic                       evt_hit;

  logic [EVT_W-1:0]           mem [DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [LVL_W-1:0]           level_q;
  logic                       overflow_q;
  logic [7:0]                 drop_q;

  logic                       full;
  logic                       empty;
  logic                       pop;
  logic                       push;
  logic                       drop;
  logic [EVT_W-1:0]           head;

  // Per-channel change detect against the previous sample; masked until primed.
  always_comb begin
    mask = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mask[k] = primed_q &&
                (ch_data[k*DATA_W +: DATA_W] != prev_q[k*DATA_W +: DATA_W]);
    end
  end

  assign evt_hit = en && (mask != '0);

  // FIFO handshake: clr wins over everything; a pop frees a slot for a same-cycle push.
  always_comb begin
    full  = (level_q == FULL_LVL);
    empty = (level_q == '0);
    pop   = rd_en && !empty && !clr;
    push  = evt_hit && !clr && (!full || pop);
    drop  = evt_hit && !clr && full && !pop;
  end

  // Timestamp, previous sample and primed flag advance only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else if (en) begin
      ts_q     <= ts_q + TS_W'(1);
      prev_q   <= ch_data;
      primed_q <= 1'b1;
    end else begin
      primed_q <= 1'b0;
    end
  end

  // Event storage; contents are don't-care until written, outputs are gated by evt_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {ts_q, mask, ch_data};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clr) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign head = mem[rd_ptr];

  // Head fields fall through and read as zero while the FIFO is empty.
  always_comb begin
    evt_valid = !empty;
    evt_ts    = '0;
    evt_mask  = '0;
    evt_data  = '0;
    if (!empty) begin
      {evt_ts, evt_mask, evt_data} = head;
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: doc/change_logger.md
CHANGE_LOGGER -- requirements
Module: change_logger

Interface
REQ-001 Parameter DATA_W, default 4: bit width of one monitored channel.
REQ-002 Parameter CHANNELS, default 2: number of monitored channels (1..8).
REQ-003 Parameter DEPTH, default 8: event FIFO entries; SHALL be a power of 2, at least 2.
REQ-004 Parameter TS_W, default 16: timestamp counter width.
REQ-005 Derived width EVT_W = TS_W + CHANNELS + CHANNELS*DATA_W.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  monitoring enable; when low, no sampling, no timestamp advance.
REQ-009 ch_data  in  CHANNELS*DATA_W  channel data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 rd_en  in  1  pop request for the head event.
REQ-011 clr  in  1  synchronous clear of overflow, drop_cnt and the FIFO.
REQ-012 evt_valid  out  1  FIFO non-empty; head event presented.
REQ-013 evt_ts  out  TS_W  timestamp of the head event.
REQ-014 evt_mask  out  CHANNELS  per-channel changed flags of the head event.
REQ-015 evt_data  out  CHANNELS*DATA_W  snapshot of all channels of the head event.
REQ-016 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 overflow  out  1  sticky: an event was dropped.
REQ-018 drop_cnt  out  8  count of dropped events, saturating at 255.

Function
REQ-019 Timestamp counter SHALL increment by 1 each cycle en=1, wrap from 2^TS_W-1 to 0, and hold when en=0.
REQ-020 On each cycle with en=1 the block SHALL register ch_data into a previous-sample register.
REQ-021 mask[k] SHALL be 1 when channel k of ch_data differs from the previous sample and primed=1.
REQ-022 primed SHALL clear on reset and on en=0, and set after the first sampled cycle with en=1; the first sample after reset or re-enable SHALL NOT generate an event.
REQ-023 An event SHALL be generated when en=1 and mask is non-zero; at most one event per cycle, with all simultaneous channel changes merged into one mask.
REQ-024 Event fields: ts = timestamp value in the sampling cycle, mask, data = current ch_data.
REQ-025 FIFO SHALL be first-word-fall-through: evt_valid = (level != 0); head fields valid whenever evt_valid=1.
REQ-026 rd_en with evt_valid=1 SHALL pop the head at the clock edge; rd_en with evt_valid=0 SHALL be ignored.
REQ-027 An event written to an empty FIFO SHALL appear on the outputs one cycle after its sampling edge.
REQ-028 Push and pop in the same cycle SHALL both occur; level unchanged; this SHALL be allowed when full.
REQ-029 An event arriving when full with no pop SHALL be dropped: FIFO unchanged, overflow set, drop_cnt += 1 unless at 255.
REQ-030 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH.
REQ-031 clr=1 SHALL empty the FIFO and zero overflow and drop_cnt at the edge; any event in that cycle SHALL be discarded without counting; timestamp and previous-sample state SHALL be unaffected.
REQ-032 evt_ts/evt_mask/evt_data SHALL be zero when evt_valid=0.

Reset
REQ-033 rst_n=0 SHALL immediately force timestamp=0, primed=0, previous-sample=0, level=0, evt_valid=0, overflow=0, drop_cnt=0 and all event outputs to 0.
REQ-034 Deassertion mid-operation SHALL lose all queued events; first event requires one primed sample.

Verification
REQ-035 DATA_W=4, CHANNELS=1, en=1, ch0 = 2,4,8,12 each held 10 cycles from ts=0 -> events ts=10,20,30 with data 4,8,12, mask=1; no event for initial 2.
REQ-036 CHANNELS=2, both channels change in the same cycle -> one event, mask=2'b11, level increments by 1.
REQ-037 DEPTH=8, 10 changes with rd_en=0 -> level=8, overflow=1, drop_cnt=2; popping returns first 8 in order.
REQ-038 Full FIFO, change with rd_en=1 same cycle -> level stays 8, no drop, new event at tail.
REQ-039 TS_W=4, en held 20 cycles, change at cycle 17 -> evt_ts=1 (wrapped).
REQ-040 rst_n low for 1 ns mid-run with 3 queued -> evt_valid=0, level=0 immediately; next change after one primed sample logged with ts counted from 0.
